// File: rtl/fpu_pkg.sv
// ============================================================================
// Module      : fpu_pkg
// Description : Shared FPU types: stage state encoding and mul-to-add bundle
//               layout so producers and consumers pack fields identically.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_pkg;

  // Elastic stage state encoding; the value doubles as the occupancy count
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  // Mul-to-add bundle: 40+40+23+10+8+2+1+1+1 = 126 bits, LSB first
  localparam int unsigned FPU_MA_W          = 126;
  localparam int unsigned FPU_MA_SUM_LSB    = 0;
  localparam int unsigned FPU_MA_SUM_W      = 40;
  localparam int unsigned FPU_MA_CARRY_LSB  = 40;
  localparam int unsigned FPU_MA_CARRY_W    = 40;
  localparam int unsigned FPU_MA_FRAC_LSB   = 80;
  localparam int unsigned FPU_MA_FRAC_W     = 23;
  localparam int unsigned FPU_MA_EXP_LSB    = 103;
  localparam int unsigned FPU_MA_EXP_W      = 10;
  localparam int unsigned FPU_MA_SHAMT_LSB  = 113;
  localparam int unsigned FPU_MA_SHAMT_W    = 8;
  localparam int unsigned FPU_MA_RM_LSB     = 121;
  localparam int unsigned FPU_MA_RM_W       = 2;
  localparam int unsigned FPU_MA_SIGN_BIT   = 123;
  localparam int unsigned FPU_MA_INF_BIT    = 124;
  localparam int unsigned FPU_MA_NAN_BIT    = 125;

endpackage

`default_nettype wire

// File: rtl/fpu_pipe_stage.sv
// ============================================================================
// Module      : fpu_pipe_stage
// Description : Elastic valid/ready pipeline register with 2-entry skid
//               buffer, synchronous flush and occupancy output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_pipe_stage
  import fpu_pkg::*;
#(
  parameter int unsigned WIDTH          = FPU_MA_W,
  parameter bit          CLEAR_ON_FLUSH = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;

  logic [1:0] w_state_nxt;
  logic       w_accept;
  logic       w_emit;
  logic       w_load_main;
  logic       w_load_skid;
  logic       w_main_from_skid;

  // Ready depends only on registered state (and reset), never on out_ready
  assign in_ready  = (r_state != FULL) && !clr;
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_main;
  assign occupancy = r_state;

  assign w_accept = in_valid && in_ready;
  assign w_emit   = out_valid && out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_nxt = BUSY;
          w_load_main = 1'b1;
        end
      end
      BUSY: begin
        if (w_accept && w_emit) begin
          w_load_main = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = FULL;
          w_load_skid = 1'b1;
        end else if (w_emit) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_emit) begin
          w_state_nxt      = BUSY;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      // Any accept this cycle is dropped; payload optionally scrubbed
      r_state <= EMPTY;
      if (CLEAR_ON_FLUSH) begin
        r_main <= '0;
        r_skid <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (w_load_main) begin
        r_main <= in_data;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= in_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpu_pipe_stage.sv
// ============================================================================
// Module      : tb_fpu_pipe_stage
// Description : Scoreboard bench for fpu_pipe_stage (default and clearing
//               flush variants driven in lockstep).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_pipe_stage;

  localparam int unsigned W = 126;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;

  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;
  logic         in_ready_c, out_valid_c;
  logic [W-1:0] out_data_c;
  logic [1:0]   occupancy_c;

  int n_vec  = 0;
  int n_miss = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  fpu_pipe_stage #(.WIDTH(W), .CLEAR_ON_FLUSH(1'b0)) dut (
    .clk(clk), .clr(clr), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  fpu_pipe_stage #(.WIDTH(W), .CLEAR_ON_FLUSH(1'b1)) dut_c (
    .clk(clk), .clr(clr), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
    .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
    .occupancy(occupancy_c)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every downstream handshake
  always @(negedge clk) begin
    logic [W-1:0] e;
    #2;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_emit", out_data, '1);
      end else begin
        e = exp_q.pop_front();
        chk("emit_data", out_data, e);
        chk("emit_data_clrvariant", out_data_c, e);
      end
    end
    if (out_valid !== out_valid_c || occupancy !== occupancy_c)
      chk("variant_agree", {out_valid_c, occupancy_c}, {out_valid, occupancy});
  end

  // One cycle of stimulus; expected payload pushed when the accept happens
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic ordy,
                     input logic fl, input logic rs);
    logic rdy0, clr0;
    @(negedge clk);
    rdy0 = in_ready;
    clr0 = clr;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    clr       = rs;
    #1;
    if (clr0 == rs) chk("in_ready_registered", {{(W-1){1'b0}}, in_ready}, {{(W-1){1'b0}}, rdy0});
    #2;
    if (rs || fl) exp_q.delete();
    else if (v && in_ready) exp_q.push_back(d);
  endtask

  task automatic chk_st(input string name, input logic rdy, input logic vld, input logic [1:0] occ);
    chk({name, "_in_ready"},  {{(W-1){1'b0}}, in_ready},  {{(W-1){1'b0}}, rdy});
    chk({name, "_out_valid"}, {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, vld});
    chk({name, "_occupancy"}, {{(W-2){1'b0}}, occupancy}, {{(W-2){1'b0}}, occ});
  endtask

  initial begin
    logic [W-1:0] seq;
    // Reset with input offered
    cyc(1, 'h5A, 0, 0, 1);  chk_st("rst0", 0, 0, 0);
    cyc(1, 'h5A, 0, 0, 1);  chk_st("rst1", 0, 0, 0);
    chk("rst_data", out_data, '0);
    cyc(1, 'h5A, 0, 0, 0);  chk_st("rst_rel", 1, 0, 0);
    cyc(0, '0, 1, 0, 0);    chk_st("first", 1, 1, 1);  chk("first_data", out_data, 'h5A);
    cyc(0, '0, 0, 0, 0);    chk_st("first_empty", 1, 0, 0);

    // Streaming
    cyc(1, 'h1, 1, 0, 0);
    cyc(1, 'h2, 1, 0, 0);   chk_st("str0", 1, 1, 1);  chk("str_d1", out_data, 'h1);
    cyc(1, 'h3, 1, 0, 0);   chk("str_d2", out_data, 'h2);  chk_st("str1", 1, 1, 1);
    cyc(1, 'h4, 1, 0, 0);   chk("str_d3", out_data, 'h3);
    cyc(0, '0, 1, 0, 0);    chk("str_d4", out_data, 'h4);  chk_st("str2", 1, 1, 1);
    cyc(0, '0, 0, 0, 0);    chk_st("str_end", 1, 0, 0);

    // Back-pressure
    cyc(1, 'hA, 0, 0, 0);
    cyc(1, 'hB, 0, 0, 0);   chk_st("bp1", 1, 1, 1);  chk("bp_a", out_data, 'hA);
    cyc(1, 'hF, 0, 0, 0);   chk_st("bp2", 0, 1, 2);  chk("bp_a_hold", out_data, 'hA);
    cyc(0, '0, 0, 0, 0);    chk_st("bp3", 0, 1, 2);  chk("bp_a_stable", out_data, 'hA);
    cyc(0, '0, 1, 0, 0);    chk("bp_emit_a", out_data, 'hA);
    cyc(0, '0, 1, 0, 0);    chk("bp_emit_b", out_data, 'hB);  chk_st("bp4", 1, 1, 1);
    cyc(0, '0, 0, 0, 0);    chk_st("bp_end", 1, 0, 0);

    // Flush while FULL, input offered in the same cycle
    cyc(1, 'h11, 0, 0, 0);
    cyc(1, 'h22, 0, 0, 0);
    cyc(1, 'hC, 0, 1, 0);   chk_st("fl_full", 0, 1, 2);
    cyc(0, '0, 0, 0, 0);    chk_st("fl_after", 1, 0, 0);
    chk("fl_hold_data", out_data, 'h11);
    chk("fl_clear_data", out_data_c, '0);
    // Flush in BUSY drops the simultaneously accepted input
    cyc(1, 'h33, 0, 0, 0);
    cyc(1, 'h44, 0, 1, 0);  chk_st("fl_busy", 1, 1, 1);
    cyc(0, '0, 0, 0, 0);    chk_st("fl_busy_after", 1, 0, 0);
    // Emit in the flush cycle still counts downstream
    cyc(1, 'h55, 0, 0, 0);
    cyc(0, '0, 1, 1, 0);    chk("fl_emit_data", out_data, 'h55);
    cyc(0, '0, 0, 0, 0);    chk_st("fl_emit_after", 1, 0, 0);

    // Simultaneous accept and emit in BUSY
    cyc(1, 'hD, 0, 0, 0);
    cyc(1, 'hE, 1, 0, 0);   chk("ae_d", out_data, 'hD);  chk_st("ae0", 1, 1, 1);
    cyc(0, '0, 0, 0, 0);    chk("ae_e", out_data, 'hE);  chk_st("ae1", 1, 1, 1);
    cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 0, 0, 0);    chk_st("ae_end", 1, 0, 0);

    // clr while FULL
    cyc(1, 'h66, 0, 0, 0);
    cyc(1, 'h77, 0, 0, 0);
    cyc(0, '0, 0, 0, 1);    chk_st("clr_mid", 0, 1, 2);
    cyc(0, '0, 0, 0, 0);    chk_st("clr_after", 1, 0, 0);
    chk("clr_data", out_data, '0);

    // Random traffic against the scoreboard
    seq = 'h1000;
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)), seq, ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 49) == 0), 1'b0);
      seq = seq + 1;
    end
    for (int i = 0; i < 4; i++) cyc(0, '0, 1, 0, 0);
    chk("drain_empty", {{(W-1){1'b0}}, out_valid}, '0);
    chk("scoreboard_empty", W'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
